// File: rtl/mem_responder_if.sv
// Requester-to-responder memory strobe bundle.
interface mem_responder_if;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] rdata;
  logic          mem_ready;
  logic          mem_err;
  logic          busy;

  modport master (
    output addr, wdata, mem_read, mem_write,
    input  rdata, mem_ready, mem_err, busy
  );

  modport slave (
    input  addr, wdata, mem_read, mem_write,
    output rdata, mem_ready, mem_err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder: one request at a time, programmable wait
// states, internal word RAM, one-cycle ready pulse with error flag.
module mem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  // Reject parameter values the datapath cannot represent.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || WAIT_CYCLES > 15) begin : g_bad_param
    $error("mem_responder: DEPTH must be a power of two >= 4 and WAIT_CYCLES <= 15");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_DONE
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          cap_c;
  logic          err_c;
  logic          ram_we_c;
  logic          ram_re_c;

  logic          op_write;
  logic          err;
  logic [AW-1:0] idx;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] ram [DEPTH];

  // Request legality, judged on the live bus at the capture edge.
  always_comb begin
    err_c = (bus.addr[1:0] != 2'b00)
         || ({2'b00, bus.addr[31:2]} >= DEPTH)
         || (bus.mem_read && bus.mem_write);
  end

  // Next-state, wait counter and access strobes.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    cap_c    = 1'b0;
    ram_we_c = 1'b0;
    ram_re_c = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          cap_c   = 1'b1;
          cnt_n   = CW'(WAIT_CYCLES);
          state_n = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        cnt_n = cnt - CW'(1);
        if (cnt <= CW'(1)) begin
          state_n = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        ram_we_c = op_write && !err;
        ram_re_c = !op_write && !err;
        state_n  = ST_DONE;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Request capture; later bus changes are ignored until the next IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_write <= 1'b0;
      err      <= 1'b0;
      idx      <= '0;
      wdata_q  <= '0;
    end else if (cap_c) begin
      op_write <= bus.mem_write;
      err      <= err_c;
      idx      <= bus.addr[AW+1:2];
      wdata_q  <= bus.wdata;
    end
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rdata     <= '0;
      bus.mem_ready <= 1'b0;
      bus.mem_err   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      if (ram_re_c) begin
        bus.rdata <= ram[idx];
      end
      bus.mem_ready <= (state_n == ST_DONE);
      bus.mem_err   <= (state_n == ST_DONE) && err;
      bus.busy      <= (state_n != ST_IDLE);
    end
  end

  // RAM write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      ram[idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: random and directed transfers against
// a word-array reference model, plus a wait-state latency sweep.
module tb_mem_responder;
  localparam int unsigned MDEPTH = 16;
  localparam int unsigned MWAIT  = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sw_reset = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   sweep_done = 0;

  exp_t        sbq[$];
  logic [31:0] mdl [MDEPTH];
  logic [31:0] mrd;
  bit          prev_rdy;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder_if bif ();
  mem_responder #(.DEPTH(MDEPTH), .WAIT_CYCLES(MWAIT)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: applies the transfer and queues its expected completion.
  function automatic void push(input bit rd, input bit wr, input logic [31:0] a,
                               input logic [31:0] d, input int acc);
    exp_t e;
    bit   bad;
    bad = (a % 4 != 0) || (a / 4 >= MDEPTH) || (rd && wr);
    if (!bad) begin
      if (wr) mdl[a / 4] = d;
      else    mrd = mdl[a / 4];
    end
    e.rdata = mrd;
    e.err   = bad;
    e.acc   = acc;
    sbq.push_back(e);
  endfunction

  // Monitor: every ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      prev_rdy = 1'b0;
    end else begin
      if (bif.mem_ready) begin
        chk("ready_single", 32'(prev_rdy), 32'd0);
        chk("ready_expected", 32'(sbq.size() > 0), 32'd1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("rdata", bif.rdata, e.rdata);
          chk("mem_err", 32'(bif.mem_err), 32'(e.err));
          chk("latency", 32'(cyc + 1 - e.acc), 32'(MWAIT + 2));
          chk("busy_done", 32'(bif.busy), 32'd1);
        end
      end
      prev_rdy = bif.mem_ready;
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bif.mem_ready && n < 40);
    if (!bif.mem_ready) chk("ready_timeout", 32'(bif.mem_ready), 32'd1);
  endtask

  // One transfer; hold keeps the strobe up into IDLE to start a second one.
  task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input bit hold);
    @(negedge clk);
    bif.addr = a; bif.wdata = d; bif.mem_read = rd; bif.mem_write = wr;
    push(rd, wr, a, d, cyc + 1);
    @(negedge clk);
    chk("busy_rise", 32'(bif.busy), 32'd1);
    bif.addr = $urandom; bif.wdata = $urandom;
    wait_ready();
    if (hold) begin
      bif.addr = a; bif.wdata = d;
      push(rd, wr, a, d, cyc + 2);
      @(negedge clk);
      chk("busy_idle", 32'(bif.busy), 32'd0);
      @(negedge clk);
      chk("busy_rerise", 32'(bif.busy), 32'd1);
      bif.mem_read = 1'b0; bif.mem_write = 1'b0;
      bif.addr = $urandom; bif.wdata = $urandom;
      wait_ready();
    end
    bif.mem_read = 1'b0; bif.mem_write = 1'b0;
  endtask

  // Latency sweep over several wait-state settings.
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int unsigned SW = (g == 0) ? 0 : ((g == 1) ? 1 : 5);
    mem_responder_if sif ();
    mem_responder #(.DEPTH(MDEPTH), .WAIT_CYCLES(SW)) u_sw (
      .clk   (clk),
      .reset (sw_reset),
      .bus   (sif)
    );
    initial begin
      int          acc;
      int          n;
      logic [31:0] v;
      sif.mem_read = 1'b0; sif.mem_write = 1'b0; sif.addr = '0; sif.wdata = '0;
      @(posedge sw_reset);
      v = 32'hC0DE_0000 + 32'(g);
      for (int op = 0; op < 2; op++) begin
        @(negedge clk);
        sif.addr = 32'hC; sif.wdata = v;
        sif.mem_write = (op == 0); sif.mem_read = (op == 1);
        acc = cyc + 1;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!sif.mem_ready && n < 40);
        sif.mem_read = 1'b0; sif.mem_write = 1'b0;
        chk("sweep_latency", 32'(cyc + 1 - acc), 32'(SW + 2));
        if (op == 1) begin
          chk("sweep_rdata", sif.rdata, v);
          chk("sweep_err", 32'(sif.mem_err), 32'd0);
        end
      end
      sweep_done++;
    end
  end

  initial begin
    int          kind;
    int          n;
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;

    bif.addr = '0; bif.wdata = '0; bif.mem_read = 1'b0; bif.mem_write = 1'b0;
    mrd = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", bif.rdata, 32'd0);
    chk("rst_ready", 32'(bif.mem_ready), 32'd0);
    chk("rst_err", 32'(bif.mem_err), 32'd0);
    chk("rst_busy", 32'(bif.busy), 32'd0);
    reset = 1'b1;
    sw_reset = 1'b1;

    // Preload every word so later reads are defined.
    for (int i = 0; i < MDEPTH; i++) begin
      issue(1'b0, 1'b1, 32'(i * 4), (i == 8) ? 32'h0 : $urandom, 1'b0);
    end

    issue(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);

    // Error cases leave rdata and RAM untouched.
    issue(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
    issue(1'b1, 1'b0, 32'(4 * MDEPTH), 32'h0, 1'b0);
    issue(1'b1, 1'b1, 32'h8, 32'h1234, 1'b0);
    issue(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);

    // Reset during WAIT discards the pending write.
    @(negedge clk);
    bif.addr = 32'h20; bif.wdata = 32'hA5A5_A5A5; bif.mem_write = 1'b1;
    @(negedge clk);
    chk("busy_before_abort", 32'(bif.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_rdata", bif.rdata, 32'd0);
    chk("abort_ready", 32'(bif.mem_ready), 32'd0);
    chk("abort_err", 32'(bif.mem_err), 32'd0);
    chk("abort_busy", 32'(bif.busy), 32'd0);
    bif.mem_write = 1'b0;
    mrd = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    issue(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

    // Strobe held through DONE starts exactly one more transfer.
    issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 9);
      rd = 1'(($urandom_range(0, 1)));
      wr = !rd;
      a = 32'($urandom_range(0, MDEPTH - 1)) << 2;
      d = $urandom;
      if (kind == 0) a = a + 32'($urandom_range(1, 3));
      else if (kind == 1) a = 32'($urandom_range(MDEPTH, 1 << 20)) << 2;
      else if (kind == 2) begin rd = 1'b1; wr = 1'b1; end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(rd, wr, a, d, ($urandom_range(0, 7) == 0));
    end

    repeat (MWAIT + 6) @(negedge clk);
    n = 0;
    while (sweep_done < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("sweep_complete", 32'(sweep_done), 32'd3);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
